regfile_scoreboard: RTL

//  Parametrised integer register file for the core: NREAD combinational read ports, one write port,

---
 rtl/regfile_scoreboard_pkg.sv | 7 +
 rtl/regfile_busy_tracker.sv | 56 +++++
 rtl/regfile_scoreboard.sv | 77 +++++++
 3 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants for the register file and its busy scoreboard.
package regfile_scoreboard_pkg;

    localparam int XLEN_DEFAULT = 32;  // core integer data width
    localparam int REG_ZERO     = 0;   // index of the hardwired-zero register

endpackage : regfile_scoreboard_pkg

// File: rtl/regfile_busy_tracker.sv
// Per-register busy bits with set-over-clear priority and a registered count of busy entries.
module regfile_busy_tracker
    import regfile_scoreboard_pkg::*;
#(
    parameter  int DEPTH    = 32,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             iss_en_i,
    input  logic [AW-1:0]    iss_addr_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    output logic [DEPTH-1:0] busy_o,
    output logic [CW-1:0]    busy_cnt_o
);

    localparam bit ZERO_REG_B = (ZERO_REG != 0);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             set_ok, clr_ok, set_eff, clr_eff;

    assign set_ok = iss_en_i && !(ZERO_REG_B && iss_addr_i == AW'(REG_ZERO));
    assign clr_ok = wr_en_i  && !(ZERO_REG_B && wr_addr_i  == AW'(REG_ZERO));

    // The count only moves on real 0->1 / 1->0 transitions so it always equals popcount(busy).
    assign set_eff = set_ok && !busy_q[iss_addr_i];
    assign clr_eff = clr_ok && busy_q[wr_addr_i] && !(iss_en_i && iss_addr_i == wr_addr_i);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        busy_d = busy_q;
        // NOTE: blocking '=' here so the later set overrides the clear on a shared address;
        // the flops below use non-blocking '<=' only.
        if (clr_ok) busy_d[wr_addr_i]  = 1'b0;
        if (set_ok) busy_d[iss_addr_i] = 1'b1;
        cnt_d = cnt_q + CW'(set_eff) - CW'(clr_eff);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule : regfile_busy_tracker

// File: rtl/regfile_scoreboard.sv
// Integer register file: NREAD combinational read ports, one write port, optional x0 and
// write-to-read bypass, plus a busy scoreboard so decode can stall on RAW hazards.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEFAULT,
    parameter  int DEPTH    = 32,
    parameter  int NREAD    = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    output logic [CW-1:0]         busy_cnt,
    output logic                  all_idle
);

    localparam bit ZERO_REG_B = (ZERO_REG != 0);
    localparam bit BYPASS_B   = (BYPASS != 0);

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             wr_ok;

    assign wr_ok = wr_en && !(ZERO_REG_B && wr_addr == AW'(REG_ZERO));

    // NOTE: the storage array is reset on purpose: every entry must read 0 after reset,
    // which rules out a RAM macro and costs a reset on each flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    regfile_busy_tracker #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk        (clk),
        .rstn       (rstn),
        .iss_en_i   (iss_en),
        .iss_addr_i (iss_addr),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt)
    );

    // Reads are gated by rstn so a write racing an asserted reset never reaches a read port.
    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [AW-1:0] addr;
        logic          zero, hit;

        assign addr = rd_addr[g*AW +: AW];
        assign zero = ZERO_REG_B && addr == AW'(REG_ZERO);
        assign hit  = BYPASS_B && wr_en && wr_addr == addr;

        assign rd_data[g*XLEN +: XLEN] = (!rstn || zero) ? '0 :
                                         hit             ? wr_data : mem_q[addr];
        assign rd_busy[g] = !zero && busy[addr] && !hit;
    end

    assign all_idle = (busy_cnt == '0);

endmodule : regfile_scoreboard
